// File: rtl/drap_imem_loader_if.sv
// Fetch/load bus between the DRAP fetch stage, the boot loader and the instruction memory.
// Fetch: accepted on a rising edge where fetch_req & fetch_ready are both high; each accepted request returns exactly one fetch_valid pulse, in order.
interface drap_imem_loader_if #(
  parameter int B = 32,
  parameter int W = 7
);
  logic         fetch_req;
  logic [W+1:0] fetch_pc;
  logic         fetch_ready;
  logic         fetch_valid;
  logic [B-1:0] fetch_instr;
  logic         fetch_fault;
  logic         load_start;
  logic [W-1:0] load_base;
  logic         load_wr;
  logic [B-1:0] load_data;
  logic         load_end;
  logic         load_busy;
  logic         load_ovf;
  logic         state_dbg;

  modport master (
    output fetch_req, fetch_pc, load_start, load_base, load_wr, load_data, load_end,
    input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_busy, load_ovf, state_dbg
  );

  modport slave (
    input  fetch_req, fetch_pc, load_start, load_base, load_wr, load_data, load_end,
    output fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_busy, load_ovf, state_dbg
  );
endinterface

// File: rtl/drap_imem_loader.sv
// DRAP instruction memory: synchronous-read RAM behind a LAT-stage fetch pipe,
// filled by a streaming loader that owns the RAM while in LOAD.
module drap_imem_loader #(
  parameter int           B   = 32,
  parameter int           W   = 7,
  parameter int           LAT = 1,
  parameter logic [B-1:0] NOP = '0
) (
  input logic clk,
  input logic rst_n,
  drap_imem_loader_if.slave bus
);
  typedef enum logic {ST_RUN = 1'b0, ST_LOAD = 1'b1} state_t;

  localparam logic [W-1:0] PTR_MAX = '1;

  state_t                  state, state_nxt;
  logic   [W-1:0]          wr_ptr;
  logic                    wrapped;
  logic                    ovf_q;
  logic                    ready_q;
  logic                    start_ok;
  logic                    wr_en;
  logic                    accept;
  logic                    misaligned;
  logic   [W-1:0]          word_idx;
  logic   [B-1:0]          mem [2**W];
  logic   [LAT-1:0]        v_pipe;
  logic   [LAT-1:0]        f_pipe;
  logic   [LAT-1:0][B-1:0] d_pipe;

  assign accept     = bus.fetch_req & ready_q;
  assign misaligned = |bus.fetch_pc[1:0];
  assign word_idx   = bus.fetch_pc[W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (start_ok)     state_nxt = ST_LOAD;
      ST_LOAD: if (bus.load_end) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // A load_start that coincides with a write in LOAD wins: the pointer restarts and the write is dropped.
  always_comb begin
    bus.load_busy = 1'b0;
    bus.state_dbg = 1'b0;
    start_ok      = 1'b0;
    wr_en         = 1'b0;
    case (state)
      ST_RUN:  start_ok = bus.load_start & ~bus.load_end;
      ST_LOAD: begin
        bus.load_busy = 1'b1;
        bus.state_dbg = 1'b1;
        start_ok      = bus.load_start;
        wr_en         = bus.load_wr & ~bus.load_start & ~wrapped;
      end
      default: ;
    endcase
  end

  // ready_q mirrors the next state so it is 0 in reset and rises one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_nxt == ST_RUN);
      if (start_ok) begin
        wr_ptr  <= bus.load_base;
        wrapped <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (state == ST_LOAD && bus.load_wr) begin
        if (wrapped) begin
          ovf_q <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == PTR_MAX) wrapped <= 1'b1;
        end
      end
    end
  end

  // RAM contents survive reset on purpose: the program stays loaded.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.load_data;
  end

  // Data/fault stages only move with a valid token, so the output holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      f_pipe <= '0;
      d_pipe <= '0;
    end else begin
      v_pipe[0] <= accept;
      if (accept) begin
        f_pipe[0] <= misaligned;
        d_pipe[0] <= misaligned ? NOP : mem[word_idx];
      end
      for (int k = 1; k < LAT; k++) begin
        v_pipe[k] <= v_pipe[k-1];
        if (v_pipe[k-1]) begin
          f_pipe[k] <= f_pipe[k-1];
          d_pipe[k] <= d_pipe[k-1];
        end
      end
    end
  end

  assign bus.fetch_ready = ready_q;
  assign bus.load_ovf    = ovf_q;
  assign bus.fetch_valid = v_pipe[LAT-1];
  assign bus.fetch_fault = v_pipe[LAT-1] & f_pipe[LAT-1];
  assign bus.fetch_instr = d_pipe[LAT-1];
endmodule

// File: tb/tb_drap_imem_loader.sv
// Self-checking bench for drap_imem_loader (LAT=3) against a word-array reference model.
module tb_drap_imem_loader;
  localparam int           B     = 32;
  localparam int           W     = 7;
  localparam int           LAT   = 3;
  localparam int           DEPTH = 128;
  localparam logic [B-1:0] NOP   = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drap_imem_loader_if #(.B(B), .W(W)) bus();
  drap_imem_loader #(.B(B), .W(W), .LAT(LAT), .NOP(NOP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int seen  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [B-1:0] ref_mem   [DEPTH];
  bit           ref_known [DEPTH];
  int           ld_base;
  int           ld_cnt;
  bit           exp_ovf     = 1'b0;
  bit           model_ready = 1'b0;

  logic [B:0]   exp_q[$];
  int           exp_cyc_q[$];
  logic [B:0]   sb_exp;
  int           sb_cyc;
  logic [B-1:0] last_instr = '0;

  function automatic void model_write(input logic [B-1:0] d);
    if (ld_base + ld_cnt < DEPTH) begin
      ref_mem[ld_base + ld_cnt]   = d;
      ref_known[ld_base + ld_cnt] = 1'b1;
    end else begin
      exp_ovf = 1'b1;
    end
    ld_cnt++;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      last_instr = '0;
    end else if (bus.fetch_valid) begin
      seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got instr=%h fault=%b, nothing outstanding", bus.fetch_instr, bus.fetch_fault);
      end else begin
        sb_exp = exp_q.pop_front();
        sb_cyc = exp_cyc_q.pop_front();
        if ({bus.fetch_fault, bus.fetch_instr} !== sb_exp) begin
          bad++;
          $display("FAIL fetch_data: got fault=%b instr=%h, expected fault=%b instr=%h",
                   bus.fetch_fault, bus.fetch_instr, sb_exp[B], sb_exp[B-1:0]);
        end
        total++;
        if (cyc != sb_cyc) begin
          bad++;
          $display("FAIL fetch_latency: valid at cycle %0d, expected cycle %0d", cyc, sb_cyc);
        end
      end
      last_instr = bus.fetch_instr;
    end else begin
      total++;
      if (bus.fetch_fault !== 1'b0 || bus.fetch_instr !== last_instr) begin
        bad++;
        $display("FAIL idle_hold: fault=%b instr=%h, expected fault=0 instr=%h", bus.fetch_fault, bus.fetch_instr, last_instr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_req  = 1'b0;
    bus.load_start = 1'b0;
    bus.load_wr    = 1'b0;
    bus.load_end   = 1'b0;
  endtask

  task automatic push_fetch(input logic [W+1:0] pc);
    if (pc[1:0] != 2'b00) exp_q.push_back({1'b1, NOP});
    else                  exp_q.push_back({1'b0, ref_mem[pc[W+1:2]]});
    exp_cyc_q.push_back(cyc + LAT);
  endtask

  task automatic fetch_one(input logic [W+1:0] pc);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = pc;
    if (model_ready) push_fetch(pc);
    step();
    bus.fetch_req = 1'b0;
  endtask

  task automatic load_begin(input logic [W-1:0] base);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    step();
    bus.load_start = 1'b0;
    ld_base     = int'(base);
    ld_cnt      = 0;
    exp_ovf     = 1'b0;
    model_ready = 1'b0;
  endtask

  task automatic load_write(input logic [B-1:0] d, input bit with_end);
    bus.load_wr   = 1'b1;
    bus.load_data = d;
    bus.load_end  = with_end;
    step();
    bus.load_wr  = 1'b0;
    bus.load_end = 1'b0;
    model_write(d);
    if (with_end) model_ready = 1'b1;
  endtask

  task automatic load_finish();
    bus.load_end = 1'b1;
    step();
    bus.load_end = 1'b0;
    model_ready  = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    repeat (LAT + 1) step();
  endtask

  task automatic reset_assert();
    #2;
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    exp_cyc_q.delete();
    model_ready = 1'b0;
    exp_ovf     = 1'b0;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_load_burst();
    load_begin(7'h10);
    total++;
    if (bus.load_busy !== 1'b1 || bus.fetch_ready !== 1'b0) begin
      bad++;
      $display("FAIL burst_enter: busy=%b ready=%b, expected busy=1 ready=0", bus.load_busy, bus.fetch_ready);
    end
    for (int i = 0; i < 4; i++) begin
      load_write(32'hA0 + i, 1'b0);
      total++;
      if (bus.load_busy !== 1'b1) begin
        bad++;
        $display("FAIL burst_busy: busy=%b after write %0d, expected 1", bus.load_busy, i);
      end
    end
    load_finish();
    total++;
    if (bus.load_busy !== 1'b0 || bus.fetch_ready !== 1'b1 || bus.load_ovf !== 1'b0) begin
      bad++;
      $display("FAIL burst_exit: busy=%b ready=%b ovf=%b, expected 0 1 0", bus.load_busy, bus.fetch_ready, bus.load_ovf);
    end
    for (int i = 0; i < 4; i++) fetch_one(9'h040 + 9'(4 * i));
    drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL burst_drain: %0d results missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_misaligned();
    fetch_one(9'h042);
    fetch_one(9'h041);
    fetch_one(9'h044);
    fetch_one(9'h043);
    drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL misaligned_drain: %0d results missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_latency();
    int seen0;
    seen0 = seen;
    for (int i = 0; i < 4; i++) fetch_one(9'h04C - 9'(4 * i));
    drain();
    total++;
    if (seen - seen0 != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL latency_count: got %0d results (%0d missing), expected 4", seen - seen0, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    load_begin(7'h00);
    load_write(32'hC0, 1'b1);
    load_begin(7'h7E);
    load_write(32'hB0, 1'b0);
    load_write(32'hB1, 1'b0);
    total++;
    if (bus.load_ovf !== 1'b0) begin
      bad++;
      $display("FAIL wrap_no_ovf_yet: ovf=%b, expected 0", bus.load_ovf);
    end
    load_write(32'hB2, 1'b0);
    total++;
    if (bus.load_ovf !== exp_ovf) begin
      bad++;
      $display("FAIL wrap_ovf: ovf=%b, expected %b", bus.load_ovf, exp_ovf);
    end
    load_finish();
    total++;
    if (bus.load_ovf !== 1'b1) begin
      bad++;
      $display("FAIL wrap_ovf_sticky: ovf=%b in RUN, expected 1", bus.load_ovf);
    end
    fetch_one(9'h1F8);
    fetch_one(9'h1FC);
    fetch_one(9'h000);
    drain();
    load_begin(7'h05);
    total++;
    if (bus.load_ovf !== 1'b0) begin
      bad++;
      $display("FAIL wrap_ovf_clear: ovf=%b after load_start, expected 0", bus.load_ovf);
    end
    load_finish();
    load_begin(7'h7F);
    load_write(32'hE0, 1'b0);
    load_write(32'hE1, 1'b1);
    fetch_one(9'h1FC);
    fetch_one(9'h000);
    drain();
    total++;
    if (bus.load_ovf !== exp_ovf || exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_end: ovf=%b missing=%0d, expected ovf=%b missing=0", bus.load_ovf, exp_q.size(), exp_ovf);
    end
  endtask

  task automatic test_reset();
    fetch_one(9'h040);
    fetch_one(9'h044);
    reset_assert();
    @(negedge clk);
    total++;
    if ({bus.fetch_valid, bus.fetch_fault, bus.fetch_instr, bus.load_busy, bus.load_ovf, bus.fetch_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b fault=%b instr=%h busy=%b ovf=%b ready=%b, expected all 0",
               bus.fetch_valid, bus.fetch_fault, bus.fetch_instr, bus.load_busy, bus.load_ovf, bus.fetch_ready);
    end
    reset_release();
    total++;
    if (bus.fetch_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_low: ready=%b right after release, expected 0", bus.fetch_ready);
    end
    step();
    model_ready = 1'b1;
    total++;
    if (bus.fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_high: ready=%b one cycle after release, expected 1", bus.fetch_ready);
    end
    fetch_one(9'h040);
    fetch_one(9'h000);
    drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_retained: %0d results missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_collision();
    bus.fetch_req  = 1'b1;
    bus.fetch_pc   = 9'h044;
    bus.load_start = 1'b1;
    bus.load_base  = 7'h20;
    push_fetch(9'h044);
    step();
    idle_inputs();
    ld_base = 32'h20; ld_cnt = 0; exp_ovf = 1'b0; model_ready = 1'b0;
    total++;
    if (bus.fetch_ready !== 1'b0 || bus.load_busy !== 1'b1) begin
      bad++;
      $display("FAIL collision_enter: ready=%b busy=%b, expected ready=0 busy=1", bus.fetch_ready, bus.load_busy);
    end
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 9'h048;
    load_write(32'hD0, 1'b0);
    load_write(32'hD1, 1'b0);
    step();
    step();
    total++;
    if (bus.fetch_ready !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL collision_load: ready=%b missing=%0d, expected ready=0 missing=0", bus.fetch_ready, exp_q.size());
    end
    bus.fetch_req = 1'b0;
    reset_assert();
    reset_release();
    step();
    model_ready = 1'b1;
    total++;
    if (bus.load_busy !== 1'b0 || bus.fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL collision_reset: busy=%b ready=%b, expected busy=0 ready=1", bus.load_busy, bus.fetch_ready);
    end
    fetch_one(9'h080);
    fetch_one(9'h084);
    fetch_one(9'h04C);
    drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL collision_retained: %0d results missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n;
      load_begin(7'($urandom_range(0, DEPTH - 1)));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) load_write($urandom, (i == n - 1) && ($urandom_range(0, 1) == 1));
      if (!model_ready) load_finish();
      total++;
      if (bus.load_ovf !== exp_ovf || bus.load_busy !== 1'b0) begin
        bad++;
        $display("FAIL random_load: ovf=%b busy=%b, expected ovf=%b busy=0", bus.load_ovf, bus.load_busy, exp_ovf);
      end
      // stray loader activity in RUN must change nothing
      bus.load_wr    = 1'b1;
      bus.load_data  = $urandom;
      bus.load_start = 1'b1;
      bus.load_end   = 1'b1;
      bus.load_base  = 7'($urandom);
      step();
      idle_inputs();
      total++;
      if (bus.load_busy !== 1'b0 || bus.fetch_ready !== 1'b1) begin
        bad++;
        $display("FAIL random_ignore: busy=%b ready=%b, expected busy=0 ready=1", bus.load_busy, bus.fetch_ready);
      end
      for (int f = 0; f < 12; f++) begin
        int idx;
        logic [W+1:0] pc;
        idx = 16;
        for (int t = 0; t < 200; t++) begin
          int c;
          c = $urandom_range(0, DEPTH - 1);
          if (ref_known[c]) begin idx = c; break; end
        end
        pc = 9'(idx * 4);
        if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
        fetch_one(pc);
        if ($urandom_range(0, 2) == 0) step();
      end
      drain();
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL random_drain: round %0d, %0d results missing, expected 0", r, exp_q.size());
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_inputs();
    bus.fetch_pc  = '0;
    bus.load_base = '0;
    bus.load_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    model_ready = 1'b1;

    test_load_burst();
    test_misaligned();
    test_latency();
    test_wrap();
    test_reset();
    test_collision();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
